// File: rtl/present80_enc_iter.sv
// Iterative PRESENT-80 encryption core, one round per clock, plus its 4-bit S-box.
// Latency: out_valid rises NUM_ROUNDS cycles after the accepting edge.
// Backpressure: in_ready is low from acceptance until the result is taken; DONE holds until out_ready.

// PRESENT 4-bit S-box, purely combinational.
module present (
  input  logic [3:0] x,
  output logic [3:0] s
);

  // Table lookup of the PRESENT S-box
  always_comb begin
    case (x)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
  end

endmodule

module present80_enc_iter #(
  parameter int NUM_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext,
  output logic        busy
);

  localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t        fsm, fsm_nxt;
  logic [63:0] blk;
  logic [79:0] keyreg;
  logic [4:0]  rnd;

  logic [63:0] t;
  logic [63:0] sb;
  logic [63:0] perm;
  logic [79:0] krot;
  logic [3:0]  ks_nib;
  logic [79:0] knext;
  logic        last_rnd;

  // addRoundKey with the top 64 bits of the current key register
  assign t = blk ^ keyreg[79:16];

  // sBoxLayer: sixteen parallel S-boxes
  for (genvar j = 0; j < 16; j++) begin : g_sbox
    present u_sbox (
      .x (t[4*j+3:4*j]),
      .s (sb[4*j+3:4*j])
    );
  end

  // pLayer: bit i moves to (16*i) mod 63, bit 63 is fixed
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign perm[(16*i) % 63] = sb[i];
  end
  assign perm[63] = sb[63];

  // Key schedule: rotate left by 61 (= right by 19), S-box the top nibble, mix in the round counter
  assign krot = {keyreg[18:0], keyreg[79:19]};

  present u_ks_sbox (
    .x (krot[79:76]),
    .s (ks_nib)
  );

  assign knext    = {ks_nib, krot[75:20], krot[19:15] ^ rnd, krot[14:0]};
  assign last_rnd = (rnd == LAST_RND);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_rnd) fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, one round per RUN cycle, whitening on the final round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk        <= '0;
      keyreg     <= '0;
      rnd        <= '0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            blk    <= plaintext;
            keyreg <= key;
            rnd    <= 5'd1;
          end
        end
        RUN: begin
          blk    <= perm;
          keyreg <= knext;
          rnd    <= rnd + 5'd1;
          if (last_rnd) ciphertext <= perm ^ knext[79:16];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present80_enc_iter.sv
// Self-checking bench for present80_enc_iter: known vectors, randomized vectors vs a reference model,
// Latency: checks out_valid exactly NUM_ROUNDS edges after acceptance.
// Backpressure: holds out_ready low in DONE, ignores in_valid during RUN, back-to-back and mid-run reset.
module tb_present80_enc_iter;

  localparam int NR = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] sbt [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present80_enc_iter #(.NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Reference PRESENT-80 encryption following the cipher description directly
  function automatic logic [63:0] model(input logic [63:0] pt, input logic [79:0] k0, input int rounds);
    logic [63:0] s;
    logic [63:0] ns;
    logic [79:0] k;
    logic [4:0]  rc;
    s = pt;
    k = k0;
    for (int r = 1; r <= rounds; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbt[s[4*n +: 4]];
      ns = '0;
      for (int b = 0; b < 64; b++) begin
        if (b == 63) ns[63] = s[63];
        else         ns[(16*b) % 63] = s[b];
      end
      s = ns;
      k = (k << 61) | (k >> 19);
      k[79:76] = sbt[k[79:76]];
      rc = 5'(r);
      k[19:15] = k[19:15] ^ rc;
    end
    return s ^ k[79:16];
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block; returns just after the accepting edge, then scrambles the inputs
  task automatic offer(input logic [63:0] pt, input logic [79:0] k);
    @(negedge clk);
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    plaintext = ~pt;
    key       = ~k;
  endtask

  // Count edges until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input logic [63:0] exp_ct);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_in_ready", in_ready, 1);
    chk("consume_out_valid", out_valid, 0);
    chk("ct_persist", ciphertext, exp_ct);
  endtask

  task automatic rand_vec(output logic [63:0] pt, output logic [79:0] k);
    logic [31:0] r;
    r  = $urandom;
    pt = {$urandom, $urandom};
    k  = {r[15:0], $urandom, $urandom};
  endtask

  logic [63:0] kv_pt  [4] = '{64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
  logic [79:0] kv_key [4] = '{80'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 80'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
  logic [63:0] kv_ct  [4] = '{64'h5579c1387b228445, 64'he72c46c0f5945049,
                              64'ha112ffc72f68417b, 64'h3333dcd3213210d2};

  initial begin
    int          lat;
    logic [63:0] pt, pt2, exp;
    logic [79:0] k, k2;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ct", ciphertext, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors
    for (int v = 0; v < 4; v++) begin
      offer(kv_pt[v], kv_key[v]);
      chk("run_busy", busy, 1);
      chk("run_in_ready", in_ready, 0);
      wait_done(lat);
      chk("kat_latency", lat, NR);
      chk("kat_ct", ciphertext, kv_ct[v]);
      chk("done_busy", busy, 0);
      if (v == 3) begin
        for (int c = 0; c < 10; c++) begin
          @(posedge clk);
          #1;
          chk("hold_out_valid", out_valid, 1);
          chk("hold_ct", ciphertext, kv_ct[v]);
          chk("hold_in_ready", in_ready, 0);
        end
      end
      consume(kv_ct[v]);
    end

    // in_valid toggled with other data during RUN must be ignored
    rand_vec(pt, k);
    exp = model(pt, k, NR);
    offer(pt, k);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid  = c[0];
      plaintext = {$urandom, $urandom};
      key       = ~k;
    end
    in_valid = 1'b0;
    wait_done(lat);
    chk("ignore_out_valid", out_valid, 1);
    chk("ignore_ct", ciphertext, exp);

    // Back-to-back: next block is offered while DONE, accepted only after returning to IDLE
    rand_vec(pt2, k2);
    @(negedge clk);
    in_valid  = 1'b1;
    plaintext = pt2;
    key       = k2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_idle_in_ready", in_ready, 1);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_out_valid", out_valid, 0);
    chk("b2b_ct_kept", ciphertext, exp);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_accept_busy", busy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    chk("b2b_latency", lat, NR);
    chk("b2b_ct", ciphertext, model(pt2, k2, NR));
    consume(model(pt2, k2, NR));

    // Randomized vectors against the reference model
    for (int v = 0; v < 8; v++) begin
      rand_vec(pt, k);
      exp = model(pt, k, NR);
      offer(pt, k);
      wait_done(lat);
      chk("rand_latency", lat, NR);
      chk("rand_ct", ciphertext, exp);
      consume(exp);
    end

    // Asynchronous reset in the middle of round 15
    rand_vec(pt, k);
    offer(pt, k);
    repeat (14) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_ct", ciphertext, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_vec(pt, k);
    exp = model(pt, k, NR);
    offer(pt, k);
    wait_done(lat);
    chk("post_rst_latency", lat, NR);
    chk("post_rst_ct", ciphertext, exp);
    consume(exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/present80_enc_iter.md
Name: present80_enc_iter

Overview:
- Iterative PRESENT-80 block-cipher encryption core, one round per clock.
- It is the direct consumer of the team's 4-bit PRESENT S-box module `present` (ports: x in, s out).
- It instantiates 16 copies for the sBoxLayer and 1 copy for the key-schedule nibble.
- Takes a 64-bit plaintext and an 80-bit key through a valid/ready handshake and returns the 64-bit ciphertext through a valid/ready handshake.

Parameters:
- NUM_ROUNDS, 31: rounds executed before final whitening.
  - Legal range is 1..31.
  - Only 31 is PRESENT-compliant; smaller values exist for debug and reduced-round tests.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  core idle and able to accept
- plaintext  input  64  block to encrypt, sampled on acceptance
- key  input  80  cipher key, sampled on acceptance
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer takes ciphertext
- ciphertext  output  64  result, registered
- busy  output  1  high while rounds are executing

Behaviour:
- Reset: asynchronous, active-low (rst_n low).
  - Clears state, key register, round counter and ciphertext to 0.
  - FSM goes to IDLE: in_ready=1, out_valid=0, busy=0.
  - Reset asserted mid-encryption aborts immediately. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid at a rising edge: state<=plaintext, keyreg<=key, rnd<=1, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - in_valid is ignored.
  - Each cycle performs round rnd:
    - t = state ^ keyreg[79:16]
    - sBoxLayer: each nibble t[4j+3:4j] goes through `present`.
    - pLayer: bit i goes to position (16*i) mod 63 for i<63; bit 63 stays at 63.
  - Each cycle also updates the key:
    - k' = keyreg rotated left by 61.
    - k'[79:76] = S(k'[79:76]).
    - k'[19:15] ^= rnd[4:0].
  - rnd increments by 1.
  - On the edge completing round NUM_ROUNDS:
    - ciphertext <= (round output) ^ (updated key)[79:16], which is the final whitening with K(NUM_ROUNDS+1).
    - out_valid<=1, busy<=0, go to DONE.
- DONE:
  - out_valid=1; ciphertext is held stable.
  - If out_ready at an edge: out_valid<=0, go to IDLE.
  - in_ready stays 0 until the IDLE state is entered. There is no same-cycle accept of a new block.
- Latency: acceptance at edge E gives out_valid=1 after edge E+NUM_ROUNDS (31 cycles for default).
  - Throughput: at most one block per NUM_ROUNDS+2 cycles.
- Round counter: 5 bits, counts 1..NUM_ROUNDS. It never wraps in normal use.
- Input stability: plaintext and key are don't-care outside the acceptance cycle, because both are captured.
- ciphertext persistence: keeps its last value after the DONE→IDLE transition, until the next completion or reset.
- Combinational paths: none from inputs to outputs. All outputs are registered or decoded from the FSM state.

Test Plan:
- pt=0000000000000000, key=0 -> ciphertext=5579c1387b228445; out_valid rises exactly 31 cycles after acceptance.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> e72c46c0f5945049.
- pt=FFFFFFFFFFFFFFFF, key=0 -> a112ffc72f68417b.
- pt=FFFFFFFFFFFFFFFF, key=all-F -> 3333dcd3213210d2; hold out_ready=0 for 10 cycles -> out_valid and ciphertext stay stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
- Toggle in_valid with a different pt during RUN -> ignored, result matches the first vector. Back-to-back: second block is accepted only after the DONE→IDLE transition.
- Pull rst_n low at round 15 -> outputs clear immediately (out_valid=0, busy=0, in_ready=1). A new encryption afterwards yields a correct vector.
